// File: rtl/wallace_mul_arbiter.sv
// Round-robin front end for one shared fixed-latency 32x32 multiplier.
// Tags ride alongside the multiplier pipe. Results land in a FIFO sized to the credit limit,
// so the non-stallable multiplier can never overrun it.
module wallace_mul_arbiter #(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned LAT    = 4,
   parameter int unsigned FDEPTH = LAT + 2,
   parameter int unsigned IDW    = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic [31:0]          mul_a,
   output logic [31:0]          mul_b,
   output logic                 mul_in_valid,
   input  logic [63:0]          mul_p,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [63:0]          rsp_p,
   output logic [IDW-1:0]       rsp_id,
   output logic                 busy
);

   localparam int unsigned CW = $clog2(FDEPTH + 1);
   localparam int unsigned PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
   localparam logic [CW-1:0] FDepthC = CW'(FDEPTH);

   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] gnt_id;
   logic           gnt_found;
   logic           credit_ok;
   logic           xfer;

   logic [31:0]    mul_a_q, mul_b_q;
   logic           mul_vld_q;
   logic [IDW-1:0] mul_id_q;

   logic [LAT-1:0] tag_vld_q;
   logic [IDW-1:0] tag_id_q [LAT];

   logic [CW-1:0]  out_q, out_d;
   logic           busy_q;

   logic [63:0]    fifo_p_q  [FDEPTH];
   logic [IDW-1:0] fifo_id_q [FDEPTH];
   logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  cnt_q;
   logic           push, pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (32'(p) == FDEPTH - 1) ? '0 : p + PW'(1);
   endfunction

   // Credit uses the registered count, so a pop frees a slot only on the next cycle.
   assign credit_ok = (out_q < FDepthC);

   // Round-robin scan from ptr_q; first valid requester wins when credit is available.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      gnt_found = 1'b0;
      gnt_id    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = (32'(ptr_q) + i) % NREQ;
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_id    = IDW'(idx);
         end
      end
      req_ready = '0;
      if (credit_ok && gnt_found) begin
         req_ready[gnt_id] = 1'b1;
      end
   end

   assign xfer  = credit_ok && gnt_found;
   assign ptr_d = !xfer ? ptr_q :
                  (32'(gnt_id) == NREQ - 1) ? '0 : gnt_id + IDW'(1);

   // Issue register: capture the granted operands and its ID; hold operands when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         mul_a_q   <= '0;
         mul_b_q   <= '0;
         mul_vld_q <= 1'b0;
         mul_id_q  <= '0;
         ptr_q     <= '0;
      end else begin
         mul_vld_q <= xfer;
         ptr_q     <= ptr_d;
         if (xfer) begin
            mul_a_q  <= req_a[32*gnt_id +: 32];
            mul_b_q  <= req_b[32*gnt_id +: 32];
            mul_id_q <= gnt_id;
         end
      end
   end

   assign mul_a        = mul_a_q;
   assign mul_b        = mul_b_q;
   assign mul_in_valid = mul_vld_q;

   // Tag pipe follows the issue strobe; the last stage lines up with mul_p.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_vld_q <= '0;
         for (int unsigned i = 0; i < LAT; i++) begin
            tag_id_q[i] <= '0;
         end
      end else begin
         tag_vld_q[0] <= mul_vld_q;
         tag_id_q[0]  <= mul_id_q;
         for (int unsigned i = 1; i < LAT; i++) begin
            tag_vld_q[i] <= tag_vld_q[i-1];
            tag_id_q[i]  <= tag_id_q[i-1];
         end
      end
   end

   assign push = tag_vld_q[LAT-1];
   assign pop  = (cnt_q != '0) && rsp_ready;

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push && !pop)      cnt_q <= cnt_q + CW'(1);
         else if (!push && pop) cnt_q <= cnt_q - CW'(1);
      end
   end

   // FIFO storage; contents are don't-care while unoccupied, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_p_q[wr_ptr_q]  <= mul_p;
         fifo_id_q[wr_ptr_q] <= tag_id_q[LAT-1];
      end
   end

   assign rsp_valid = (cnt_q != '0);
   assign rsp_p     = rsp_valid ? fifo_p_q[rd_ptr_q]  : '0;
   assign rsp_id    = rsp_valid ? fifo_id_q[rd_ptr_q] : '0;

   // Outstanding ops: +1 per transfer, -1 per pop.
   always_comb begin
      out_d = out_q;
      if (xfer && !pop)      out_d = out_q + CW'(1);
      else if (!xfer && pop) out_d = out_q - CW'(1);
   end

   // Outstanding counter and its registered nonzero flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         busy_q <= (out_d != '0);
      end
   end

   assign busy = busy_q;

   // Credit accounting guarantees a free slot for every multiplier result.
   assert property (@(posedge clk) disable iff (rst) !(push && (cnt_q == FDepthC)));

endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// Scoreboard bench for wallace_mul_arbiter with an in-bench fixed-latency multiplier.
module tb_wallace_mul_arbiter;

   localparam int NREQ   = 4;
   localparam int LAT    = 4;
   localparam int FDEPTH = LAT + 2;
   localparam int IDW    = 2;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NREQ-1:0]     req_valid;
   logic [32*NREQ-1:0]  req_a;
   logic [32*NREQ-1:0]  req_b;
   logic [NREQ-1:0]     req_ready;
   logic [31:0]         mul_a;
   logic [31:0]         mul_b;
   logic                mul_in_valid;
   logic [63:0]         mul_p;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [63:0]         rsp_p;
   logic [IDW-1:0]      rsp_id;
   logic                busy;

   wallace_mul_arbiter #(
      .NREQ   (NREQ),
      .LAT    (LAT),
      .FDEPTH (FDEPTH),
      .IDW    (IDW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_ready    (req_ready),
      .mul_a        (mul_a),
      .mul_b        (mul_b),
      .mul_in_valid (mul_in_valid),
      .mul_p        (mul_p),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_p        (rsp_p),
      .rsp_id       (rsp_id),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int          id;
      logic [63:0] p;
      int          due;
   } exp_t;
   exp_t sb[$];

   // Reference model state: rotation pointer and outstanding count.
   int m_ptr = 0;
   int m_out = 0;

   // Multiplier: product of the operands presented in cycle c appears in cycle c+LAT.
   logic [63:0] mpipe [LAT];
   always @(posedge clk) begin
      mpipe[0] <= 64'(mul_a) * 64'(mul_b);
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
   end
   assign mul_p = mpipe[LAT-1];

   // Cycle counter.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Grant prediction; each grant pushes its expected product and due cycle.
   always @(negedge clk) begin
      int gid;
      int idx;
      logic [NREQ-1:0] exp_g;
      if (rst) begin
         m_ptr = 0;
         m_out = 0;
         sb.delete();
      end else begin
         gid   = -1;
         exp_g = '0;
         if (m_out < FDEPTH) begin
            for (int i = 0; i < NREQ; i++) begin
               idx = (m_ptr + i) % NREQ;
               if (gid < 0 && req_valid[idx]) gid = idx;
            end
         end
         if (gid >= 0) exp_g[gid] = 1'b1;
         chk("req_ready", 64'(req_ready), 64'(exp_g));
         chk("busy", 64'(busy), 64'(m_out != 0));
         if (gid >= 0) begin
            sb.push_back('{id: gid,
                           p: 64'(req_a[32*gid +: 32]) * 64'(req_b[32*gid +: 32]),
                           due: cyc + LAT + 2});
            m_ptr = (gid + 1) % NREQ;
            m_out = m_out + 1;
         end
         if (rsp_valid && rsp_ready) m_out = m_out - 1;
      end
   end

   // Response monitor: in-order compare of the FIFO head, plus timing of its arrival.
   always @(negedge clk) begin
      if (!rst) begin
         if (sb.size() != 0 && sb[0].due <= cyc) chk("rsp_valid_due", 64'(rsp_valid), 64'd1);
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
               if (sb[0].due > cyc) chk("rsp_early", 64'(rsp_valid), 64'd0);
               chk("rsp_p", rsp_p, sb[0].p);
               chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
               if (rsp_ready) void'(sb.pop_front());
            end
         end
      end
   end

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 5))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'h0;
         2:       return 32'h8000_0000;
         default: return $urandom();
      endcase
   endfunction

   task automatic rnd_ops();
      for (int r = 0; r < NREQ; r++) begin
         req_a[32*r +: 32] = rnd_op();
         req_b[32*r +: 32] = rnd_op();
      end
   endtask

   task automatic drain();
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (FDEPTH + LAT + 4) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
      chk({tag, "_mul_a"}, 64'(mul_a), 64'd0);
      chk({tag, "_mul_b"}, 64'(mul_b), 64'd0);
      chk({tag, "_mul_in_valid"}, 64'(mul_in_valid), 64'd0);
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({tag, "_rsp_p"}, rsp_p, 64'd0);
      chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   // One isolated op on an idle block: grant, latency, product and ID against constants.
   task automatic issue_one(input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] p);
      int k;
      @(posedge clk); #1;
      rsp_ready          = 1'b1;
      req_valid          = '0;
      req_valid[id]      = 1'b1;
      req_a[32*id +: 32] = a;
      req_b[32*id +: 32] = b;
      @(negedge clk);
      chk("one_ready", 64'(req_ready), 64'd1 << id);
      @(posedge clk); #1;
      req_valid = '0;
      for (k = 1; k <= 3 * LAT + 8; k++) begin
         @(negedge clk);
         if (rsp_valid) break;
      end
      chk("one_latency", 64'(k), 64'(LAT + 2));
      chk("one_p", rsp_p, p);
      chk("one_id", 64'(rsp_id), 64'(id));
      repeat (2) @(posedge clk);
   endtask

   initial begin
      int n;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");

      // Directed single ops, including operand extremes.
      issue_one(2, 32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_FFFF);
      issue_one(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      issue_one(3, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000);
      drain();

      // Round-robin with every requester asserting; pointer sits at 0 after requester 3.
      @(posedge clk); #1;
      req_valid = '1;
      rnd_ops();
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (i < NREQ) chk("rr_grant", 64'(req_ready), 64'd1 << i);
         @(posedge clk); #1;
         rnd_ops();
      end
      drain();

      // Backpressure: consumer stalled, requester 0 streaming.
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = 4'b0001;
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (req_ready[0]) n++;
         @(posedge clk); #1;
         rnd_ops();
      end
      @(negedge clk);
      chk("bp_transfers", 64'(n), 64'(FDEPTH));
      chk("bp_busy", 64'(busy), 64'd1);
      chk("bp_stalled", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_pop_cycle", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_regrant", 64'(req_ready), 64'd1);
      repeat (20) begin
         @(posedge clk); #1;
         rnd_ops();
      end
      drain();

      // Simultaneous push/pop with rsp_ready toggling.
      @(posedge clk); #1;
      req_valid = '1;
      for (int i = 0; i < 40; i++) begin
         rsp_ready = i[0];
         rnd_ops();
         @(posedge clk); #1;
      end
      drain();

      // Reset while three ops are in flight.
      @(posedge clk); #1;
      req_valid = 4'b0010;
      rnd_ops();
      repeat (3) @(posedge clk);
      #1 req_valid = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      for (int i = 1; i < 2 * LAT; i++) begin
         @(negedge clk);
         chk("midrst_quiet", 64'(rsp_valid), 64'd0);
      end
      @(posedge clk); #1;
      req_valid = '1;
      rnd_ops();
      @(negedge clk);
      chk("midrst_first_grant", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      drain();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
         rnd_ops();
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      drain();
      @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      chk("end_busy", 64'(busy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
